array_multiplier: RTL and testbench
===================================

ARRAY_MULTIPLIER -- requirements
Module: array_multiplier

Interface
REQ-001 Parameter WIDTH, default 32: operand width in bits; product width is 2*WIDTH; all requirements below use WIDTH=32.
REQ-002 clk  input  1  single clock; all registers update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  qualifies multiplicand/multiplier in the current cycle.
REQ-005 multiplicand  input  WIDTH  signed two's-complement operand A.
REQ-006 multiplier  input  WIDTH  signed two's-complement operand B.
REQ-007 product  output  2*WIDTH  signed two's-complement result A*B, registered.
REQ-008 out_valid  output  1  high for exactly one cycle per accepted input, aligned with its product.

Function
REQ-009 product SHALL equal the exact mathematical signed product of multiplicand and multiplier over the full 64 bits: no truncation, saturation or overflow flag.
REQ-010 The multiply SHALL be built as an explicit array: WIDTH rows of AND-gated partial products with Baugh-Wooley sign handling (MSB-row/column terms inverted plus correction constants), summed by rows of full/half adders with a final ripple-carry row; the language multiply operator SHALL NOT be used.
REQ-011 Operands SHALL be sampled on every rising clk edge regardless of in_valid; in_valid only drives out_valid.
REQ-012 Latency SHALL be fixed: the result of operands sampled at edge N appears on product after edge N+L (L=1, or L=2 per REQ-019), with out_valid = in_valid delayed by L cycles.
REQ-013 Throughput SHALL be one new operand pair per cycle; back-to-back inputs produce back-to-back results in order.
REQ-014 Boundaries: MIN_INT*MIN_INT = 0x4000000000000000; MIN_INT*-1 = 0x0000000080000000 (positive, no wrap); any operand 0 gives 0.
REQ-015 product and out_valid SHALL hold their values between updates; no combinational path from inputs to outputs.

Reset
REQ-016 While rst is high, product = 0 and out_valid = 0 immediately (asynchronous), and all internal pipeline registers clear.
REQ-017 Asserting rst mid-operation SHALL discard all in-flight results; no stale out_valid pulse after release.
REQ-018 After rst falls, the first valid result appears L cycles after the first edge that samples in_valid=1.

Configuration
REQ-019 Macro ARRAY_MULTIPLIER_PIPE_EN: defined -> a register stage is inserted after partial-product row WIDTH/2 (sum, carry, pending low product bits and valid all staged), L=2; undefined -> single output register, L=1; results identical in both builds.

Verification
REQ-020 Reset: assert rst with non-zero inputs and in_valid=1 -> product=0, out_valid=0 without a clock edge; after release, out_valid rises L cycles after first valid sample.
REQ-021 Directed values -> 1*1=0x1; 0x12345678*0x12345678=0x014B66DC1DF4D840; -1*-1=0x1; -2*2=0xFFFFFFFFFFFFFFFC; 2*-2=0xFFFFFFFFFFFFFFFC; -1*3=0xFFFFFFFFFFFFFFFD.
REQ-022 Extremes -> 0x7FFFFFFF*0x7FFFFFFF=0x3FFFFFFF00000001; 0x80000000*0x80000000=0x4000000000000000; 0x80000000*-1=0x0000000080000000; 0x80000000*2=0xFFFFFFFF00000000; 0x7FFFFFFF*-1=0xFFFFFFFF80000001.
REQ-023 Zero -> 0*0x12345678=0 and 0x12345678*0=0.
REQ-024 Streaming: 1000 random back-to-back pairs with random in_valid gaps -> each product matches a 64-bit signed reference model at latency L, out_valid pattern equals delayed in_valid; run with and without ARRAY_MULTIPLIER_PIPE_EN.
REQ-025 Mid-stream reset: assert rst while results are in flight -> no out_valid pulses for pre-reset inputs after release.

Source files
------------

// File: rtl/array_multiplier.sv
// Signed Baugh-Wooley array multiplier, carry-save rows with a final ripple-carry row.
// Define ARRAY_MULTIPLIER_PIPE_EN to split the array after row WIDTH/2 (latency 2 instead of 1).
module array_multiplier #(
   parameter int unsigned WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic [2*WIDTH-1:0]   product,
   output logic                 out_valid
);

   localparam int unsigned PW = 2 * WIDTH;

   // Baugh-Wooley correction terms: +2^WIDTH + 2^(2*WIDTH-1)
   localparam logic [PW-1:0] BwCorr = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));

   function automatic logic [PW-1:0] pp_row(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input int               i);
      logic [PW-1:0] row;
      row = '0;
      for (int j = 0; j < int'(WIDTH); j++) begin
         // Terms with exactly one sign bit carry negative weight and are inverted
         if ((i == int'(WIDTH) - 1) != (j == int'(WIDTH) - 1)) row[i + j] = ~(a[j] & b[i]);
         else                                                  row[i + j] = a[j] & b[i];
      end
      return row;
   endfunction

   // One full-adder row per partial product in [first, last], carry-save form.
   function automatic void add_rows(input  logic [WIDTH-1:0] a,
                                    input  logic [WIDTH-1:0] b,
                                    input  int               first,
                                    input  int               last,
                                    input  logic [PW-1:0]    s_in,
                                    input  logic [PW-1:0]    c_in,
                                    output logic [PW-1:0]    s_out,
                                    output logic [PW-1:0]    c_out);
      logic [PW-1:0] s, c, p, maj;
      s   = s_in;
      c   = c_in;
      p   = '0;
      maj = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         if (i >= first && i <= last) begin
            p   = pp_row(a, b, i);
            maj = (s & c) | (s & p) | (c & p);
            s   = s ^ c ^ p;
            c   = {maj[PW-2:0], 1'b0};
         end
      end
      s_out = s;
      c_out = c;
   endfunction

   function automatic logic [PW-1:0] ripple(input logic [PW-1:0] s, input logic [PW-1:0] c);
      logic [PW-1:0] sum;
      logic          cy;
      sum = '0;
      cy  = 1'b0;
      for (int k = 0; k < int'(PW); k++) begin
         sum[k] = s[k] ^ c[k] ^ cy;
         cy     = (s[k] & c[k]) | (s[k] & cy) | (c[k] & cy);
      end
      return sum;
   endfunction

   logic [PW-1:0] product_q, product_d;
   logic          out_valid_q, out_valid_d;

`ifdef ARRAY_MULTIPLIER_PIPE_EN
   localparam int SplitRow = int'(WIDTH / 2);

   // Full-width sum/carry vectors already hold the settled low product bits.
   logic [PW-1:0]    sum_q, sum_d, carry_q, carry_d;
   logic [PW-1:0]    sum_b, carry_b;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic             valid_q, valid_d;

   always_comb begin
      a_d     = multiplicand;
      b_d     = multiplier;
      valid_d = in_valid;
      sum_d   = '0;
      carry_d = '0;
      add_rows(multiplicand, multiplier, 0, SplitRow, BwCorr, '0, sum_d, carry_d);
   end

   always_comb begin
      sum_b       = '0;
      carry_b     = '0;
      add_rows(a_q, b_q, SplitRow + 1, int'(WIDTH) - 1, sum_q, carry_q, sum_b, carry_b);
      product_d   = ripple(sum_b, carry_b);
      out_valid_d = valid_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_q   <= '0;
         carry_q <= '0;
         a_q     <= '0;
         b_q     <= '0;
         valid_q <= 1'b0;
      end else begin
         sum_q   <= sum_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         valid_q <= valid_d;
      end
   end
`else
   logic [PW-1:0] sum_f, carry_f;

   always_comb begin
      sum_f       = '0;
      carry_f     = '0;
      add_rows(multiplicand, multiplier, 0, int'(WIDTH) - 1, BwCorr, '0, sum_f, carry_f);
      product_d   = ripple(sum_f, carry_f);
      out_valid_d = in_valid;
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         product_q   <= '0;
         out_valid_q <= 1'b0;
      end else begin
         product_q   <= product_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign product   = product_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_array_multiplier.sv
// Self-checking bench for array_multiplier: directed vectors, reset behaviour, random stream.
module tb_array_multiplier;

`ifdef ARRAY_MULTIPLIER_PIPE_EN
   localparam int L = 2;
`else
   localparam int L = 1;
`endif

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [31:0] multiplicand;
   logic [31:0] multiplier;
   logic [63:0] product;
   logic        out_valid;

   int n_checks = 0;
   int n_fail   = 0;

   logic        exp_v[$];
   logic [63:0] exp_p[$];

   array_multiplier #(
      .WIDTH(32)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .multiplicand(multiplicand),
      .multiplier  (multiplier),
      .product     (product),
      .out_valid   (out_valid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: act=timeout req=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_value(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: act=0x%016h req=0x%016h", tag, act, exp);
      end
   endtask

   function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
   endfunction

   task automatic do_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp);
      @(negedge clk);
      multiplicand = a;
      multiplier   = b;
      in_valid     = 1'b1;
      repeat (L) @(posedge clk);
      #1;
      check_value({tag, "_p"}, product, exp);
      check_value({tag, "_v"}, {63'b0, out_valid}, 64'd1);
   endtask

   initial begin
      logic        ev;
      logic [63:0] ep;
      rst          = 1'b1;
      in_valid     = 1'b0;
      multiplicand = '0;
      multiplier   = '0;
      repeat (2) @(posedge clk);
      #1;
      check_value("reset_p", product, 64'd0);
      check_value("reset_v", {63'b0, out_valid}, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      do_vec("one",    32'h0000_0001, 32'h0000_0001, 64'h0000_0000_0000_0001);
      do_vec("sq",     32'h1234_5678, 32'h1234_5678, 64'h014B_66DC_1DF4_D840);
      do_vec("m1m1",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
      do_vec("m2x2",   32'hFFFF_FFFE, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFC);
      do_vec("2xm2",   32'h0000_0002, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFC);
      do_vec("m1x3",   32'hFFFF_FFFF, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFFD);
      do_vec("maxmax", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001);
      do_vec("minmin", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
      do_vec("minm1",  32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
      do_vec("minx2",  32'h8000_0000, 32'h0000_0002, 64'hFFFF_FFFF_0000_0000);
      do_vec("maxm1",  32'h7FFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0001);
      do_vec("zero_a", 32'h0000_0000, 32'h1234_5678, 64'h0);
      do_vec("zero_b", 32'h1234_5678, 32'h0000_0000, 64'h0);

      // Asynchronous reset with live inputs, then first-result latency
      @(negedge clk);
      multiplicand = 32'd5;
      multiplier   = 32'd7;
      in_valid     = 1'b1;
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_value("async_rst_p", product, 64'd0);
      check_value("async_rst_v", {63'b0, out_valid}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < L; k++) begin
         @(posedge clk);
         #1;
         check_value("first_v", {63'b0, out_valid}, (k == L - 1) ? 64'd1 : 64'd0);
      end
      check_value("first_p", product, 64'd35);

      // Random stream against a reference model
      @(negedge clk);
      in_valid = 1'b0;
      repeat (L + 1) @(posedge clk);
      for (int i = 0; i < L - 1; i++) begin
         exp_v.push_back(1'b0);
         exp_p.push_back(64'd0);
      end
      for (int k = 0; k < 1000; k++) begin
         @(negedge clk);
         multiplicand = (k % 97 == 0) ? 32'h8000_0000 : $urandom();
         multiplier   = (k % 89 == 0) ? 32'hFFFF_FFFF : $urandom();
         in_valid     = ($urandom_range(0, 3) != 0);
         @(posedge clk);
         exp_v.push_back(in_valid);
         exp_p.push_back(ref_mul(multiplicand, multiplier));
         #1;
         ev = exp_v.pop_front();
         ep = exp_p.pop_front();
         check_value("stream_v", {63'b0, out_valid}, {63'b0, ev});
         if (ev) check_value("stream_p", product, ep);
      end

      // Reset while results are in flight; no stale pulses afterwards
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         multiplicand = $urandom();
         multiplier   = $urandom();
         in_valid     = 1'b1;
      end
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_value("mid_rst_p", product, 64'd0);
      check_value("mid_rst_v", {63'b0, out_valid}, 64'd0);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         check_value("post_rst_v", {63'b0, out_valid}, 64'd0);
      end
      do_vec("post_rst", 32'h0000_0003, 32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
